// File: rtl/mul_pkg.sv
// Shared helpers for multiplier-sharing controllers: latency and ID width derivation.
package mul_pkg;

  function automatic int unsigned mul_latency(input int unsigned a_w, input int unsigned b_w);
    int unsigned m;
    int unsigned l;
    m = (a_w < b_w) ? a_w : b_w;
    l = $clog2(m);
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    int unsigned l;
    l = $clog2(n);
    return (l < 1) ? 1 : l;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  localparam int unsigned SumW = IdxW + 1;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [SumW-1:0] sum;
  logic           found;

  always_comb begin
    // Rotate so bit k of req_rot is requester (ptr + k) mod N.
    req_dbl = {req_i, req_i} >> ptr_i;
    req_rot = req_dbl[N-1:0];
    sum     = '0;
    found   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum   = {1'b0, ptr_i} + SumW'(k);
        found = 1'b1;
      end
    end
    if (sum >= SumW'(N)) begin
      sum = sum - SumW'(N);
    end
    gnt_idx_o = sum[IdxW-1:0];
    gnt_o     = (found && en_i) ? (N'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined multiplier between N_REQ requesters with round-robin issue.
// Optional statistics counters are built when MUL_SHARE_ARBITER_STATS_EN is defined.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 16,
  parameter int unsigned MUL_LATENCY = mul_latency(A_WIDTH, B_WIDTH),
  parameter int unsigned ID_W        = id_width(N_REQ)
) (
  input  logic                         clk_i,
  input  logic                         reset_an_i,
  input  logic                         reset_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ*A_WIDTH-1:0]     req_a_i,
  input  logic [N_REQ*B_WIDTH-1:0]     req_b_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic                         mul_stall_o,
  output logic                         mul_reset_o,
  output logic [A_WIDTH-1:0]           mul_a_o,
  output logic [B_WIDTH-1:0]           mul_b_o,
  input  logic [A_WIDTH+B_WIDTH-1:0]   mul_p_i,
  output logic                         rsp_valid_o,
  output logic [ID_W-1:0]              rsp_id_o,
  output logic [A_WIDTH+B_WIDTH-1:0]   rsp_data_o,
  input  logic                         rsp_ready_i,
  output logic [31:0]                  stat_issue_o,
  output logic [31:0]                  stat_stall_o
);

  localparam int unsigned PROD_W = A_WIDTH + B_WIDTH;

  logic                   stall;
  logic                   grant_en;
  logic                   issue;
  logic [N_REQ-1:0]       gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic [ID_W-1:0]        id_q [MUL_LATENCY];
  logic [ID_W-1:0]        id_d [MUL_LATENCY];

  assign stall    = vld_q[MUL_LATENCY-1] & ~rsp_ready_i;
  assign grant_en = ~stall & ~reset_i & reset_an_i;
  assign issue    = |gnt;

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (ID_W)
  ) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .en_i      (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // One-hot AND-OR mux; an idle bubble feeds zeros so its product is 0.
  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        mul_a_o = mul_a_o | req_a_i[k*A_WIDTH +: A_WIDTH];
        mul_b_o = mul_b_o | req_b_i[k*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    ptr_d = ptr_q;
    if (!stall) begin
      vld_d[0] = issue;
      id_d[0]  = gnt_idx;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        id_d[k]  = id_q[k-1];
      end
    end
    if (issue) begin
      ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_an_i) begin
    if (!reset_an_i) begin
      vld_q <= '0;
      id_q  <= '{default: '0};
      ptr_q <= '0;
    end else if (reset_i) begin
      vld_q <= '0;
      id_q  <= '{default: '0};
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
      ptr_q <= ptr_d;
    end
  end

  assign req_ready_o = gnt;
  assign mul_stall_o = stall;
  assign mul_reset_o = reset_i;
  assign rsp_valid_o = vld_q[MUL_LATENCY-1];
  assign rsp_id_o    = id_q[MUL_LATENCY-1];
  assign rsp_data_o  = PROD_W'(mul_p_i);

`ifdef MUL_SHARE_ARBITER_STATS_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i or negedge reset_an_i) begin
    if (!reset_an_i) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (reset_i) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_q + {31'd0, issue};
      stall_cnt_q <= stall_cnt_q + {31'd0, stall};
    end
  end

  assign stat_issue_o = issue_cnt_q;
  assign stat_stall_o = stall_cnt_q;
`else
  assign stat_issue_o = '0;
  assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed and scoreboarded bench for mul_share_arbiter with a behavioural pipelined multiplier.
module tb_mul_share_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned BW = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned PW = AW + BW;
`ifdef MUL_SHARE_ARBITER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_an;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            mul_stall;
  logic            mul_reset;
  logic [AW-1:0]   mul_a;
  logic [BW-1:0]   mul_b;
  logic [PW-1:0]   mul_p;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [PW-1:0]   rsp_data;
  logic            rsp_ready;
  logic [31:0]     stat_issue;
  logic [31:0]     stat_stall;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .N_REQ       (N),
    .A_WIDTH     (AW),
    .B_WIDTH     (BW),
    .MUL_LATENCY (L),
    .ID_W        (IW)
  ) dut (
    .clk_i        (clk),
    .reset_an_i   (reset_an),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .mul_stall_o  (mul_stall),
    .mul_reset_o  (mul_reset),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_p_i      (mul_p),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data),
    .rsp_ready_i  (rsp_ready),
    .stat_issue_o (stat_issue),
    .stat_stall_o (stat_stall)
  );

  // Behavioural L-stage multiplier that stalls and clears like the real one.
  logic [PW-1:0] pipe [L];
  always_ff @(posedge clk or negedge reset_an) begin
    if (!reset_an) begin
      pipe <= '{default: '0};
    end else if (mul_reset) begin
      pipe <= '{default: '0};
    end else if (!mul_stall) begin
      pipe[0] <= PW'(mul_a) * PW'(mul_b);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign mul_p = pipe[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    req_valid = 4'hF;
    reset     = 1'b1;
    #1;
    chk("clr_ready", 64'(req_ready), 64'h0);
    tick();
    reset     = 1'b0;
    req_valid = '0;
  endtask

  logic [15:0] ta [4] = '{16'hFFFF, 16'h0002, 16'h0100, 16'h1234};
  logic [15:0] tbv[4] = '{16'hFFFF, 16'h0003, 16'h0200, 16'h0005};
  logic [31:0] tp [4] = '{32'hFFFE0001, 32'h00000006, 32'h00020000, 32'h00005B04};

  task automatic load_table();
    for (int k = 0; k < N; k++) begin
      req_a[k*AW +: AW] = ta[k];
      req_b[k*BW +: BW] = tbv[k];
    end
  endtask

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] prod;
  } exp_t;
  exp_t sb[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   mp;
    int   guard;
    reset_an  = 1'b0;
    reset     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2;
    chk("por_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("por_rsp_id", 64'(rsp_id), 64'h0);
    chk("por_req_ready", 64'(req_ready), 64'h0);
    chk("por_stat_issue", 64'(stat_issue), 64'h0);
    chk("por_stat_stall", 64'(stat_stall), 64'h0);
    @(negedge clk);
    req_valid = '0;
    reset_an  = 1'b1;
    tick();

    // Single requester: 3 x 7 from requester 1.
    req_a[AW +: AW] = 16'd3;
    req_b[BW +: BW] = 16'd7;
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 64'(req_ready), 64'h2);
    chk("single_mul_a", 64'(mul_a), 64'h3);
    for (int c = 1; c < 4; c++) begin
      tick();
      req_valid = '0;
      #1;
      chk("single_ready_off", 64'(req_ready), 64'h0);
      chk("single_early", 64'(rsp_valid), 64'h0);
    end
    tick();
    #1;
    chk("single_valid", 64'(rsp_valid), 64'h1);
    chk("single_id", 64'(rsp_id), 64'h1);
    chk("single_data", 64'(rsp_data), 64'd21);
    tick();
    #1;
    chk("single_done", 64'(rsp_valid), 64'h0);

    // Round robin: all four valid for 8 cycles.
    pulse_clr();
    load_table();
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      chk("rr_ready", 64'(req_ready), (c < 8) ? 64'(1 << (c % 4)) : 64'h0);
      chk("rr_valid", 64'(rsp_valid), 64'((c >= 4) && (c < 12)));
      if (c >= 4 && c < 12) begin
        chk("rr_id", 64'(rsp_id), 64'((c - 4) % 4));
        chk("rr_data", 64'(rsp_data), 64'(tp[(c - 4) % 4]));
      end
      tick();
    end

    // Back-pressure: rsp_ready low for cycles 4..6 with four ops in flight.
    pulse_clr();
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 7) ? 4'hF : 4'h0;
      rsp_ready = (c >= 4 && c < 7) ? 1'b0 : 1'b1;
      #1;
      chk("bp_stall", 64'(mul_stall), 64'((c >= 4) && (c < 7)));
      chk("bp_ready", 64'(req_ready), (c < 4) ? 64'(1 << c) : 64'h0);
      chk("bp_valid", 64'(rsp_valid), 64'((c >= 4) && (c < 11)));
      if (c >= 4 && c < 11) begin
        chk("bp_id", 64'(rsp_id), (c < 7) ? 64'h0 : 64'(c - 7));
        chk("bp_data", 64'(rsp_data), (c < 7) ? 64'(tp[0]) : 64'(tp[c - 7]));
      end
      if (c == 7) begin
        chk("bp_stat_stall", 64'(stat_stall), StatsEn ? 64'd3 : 64'd0);
        chk("bp_stat_issue", 64'(stat_issue), StatsEn ? 64'd4 : 64'd0);
      end
      tick();
    end

    // Synchronous clear with three ops in flight.
    pulse_clr();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'hF;
      tick();
    end
    reset = 1'b1;
    #1;
    chk("sclr_ready", 64'(req_ready), 64'h0);
    tick();
    reset     = 1'b0;
    req_valid = '0;
    #1;
    chk("sclr_stat_issue", 64'(stat_issue), 64'h0);
    for (int c = 4; c < 9; c++) begin
      chk("sclr_no_rsp", 64'(rsp_valid), 64'h0);
      tick();
    end
    req_valid = 4'hF;
    #1;
    chk("sclr_ptr0", 64'(req_ready), 64'h1);
    req_valid = '0;
    tick();

    // Asynchronous reset while stalled.
    pulse_clr();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("ar_stall_pre", 64'(mul_stall), 64'h1);
    tick();
    req_valid = 4'hF;
    #1;
    chk("ar_stall_hold", 64'(mul_stall), 64'h1);
    chk("ar_ready_hold", 64'(req_ready), 64'h0);
    #2;
    reset_an = 1'b0;
    #1;
    chk("ar_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("ar_rsp_id", 64'(rsp_id), 64'h0);
    chk("ar_stall", 64'(mul_stall), 64'h0);
    chk("ar_ready", 64'(req_ready), 64'h0);
    chk("ar_mul_a", 64'(mul_a), 64'h0);
    chk("ar_stat_stall", 64'(stat_stall), 64'h0);
    #1;
    reset_an  = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();

    // Single requester continuously valid: back-to-back grants.
    pulse_clr();
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 10) ? 4'b0100 : 4'b0000;
      req_a[2*AW +: AW] = AW'(c + 1);
      req_b[2*BW +: BW] = BW'(c + 2);
      #1;
      chk("b2b_ready", 64'(req_ready), (c < 10) ? 64'h4 : 64'h0);
      chk("b2b_valid", 64'(rsp_valid), 64'(c >= 4));
      if (c >= 4) begin
        chk("b2b_id", 64'(rsp_id), 64'h2);
        chk("b2b_data", 64'(rsp_data), 64'((c - 3) * (c - 2)));
      end
      tick();
    end

    // Random traffic with scoreboard and a bench-side round-robin pointer.
    pulse_clr();
    mp = 0;
    for (int i = 0; i < 300; i++) begin
      req_valid = N'($urandom_range(0, 15));
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_onehot", 64'($onehot0(req_ready)), 64'h1);
      chk("rnd_subset", 64'(req_ready & ~req_valid), 64'h0);
      if (req_valid != '0 && !(rsp_valid && !rsp_ready)) begin
        int g;
        g = -1;
        for (int j = 0; j < N; j++) begin
          if (g < 0 && req_valid[(mp + j) % N]) g = (mp + j) % N;
        end
        chk("rnd_grant", 64'(req_ready), 64'(1 << g));
        mp = (g + 1) % N;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rnd_sb_nonempty", 64'(sb.size() != 0), 64'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rnd_id", 64'(rsp_id), 64'(e.id));
          chk("rnd_data", 64'(rsp_data), 64'(e.prod));
        end
      end
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) begin
          e.id   = IW'(k);
          e.prod = PW'(req_a[k*AW +: AW]) * PW'(req_b[k*BW +: BW]);
          sb.push_back(e);
        end
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      #1;
      if (rsp_valid) begin
        e = sb.pop_front();
        chk("drain_id", 64'(rsp_id), 64'(e.id));
        chk("drain_data", 64'(rsp_data), 64'(e.prod));
      end
      tick();
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'h0);
    #1;
    chk("drain_idle", 64'(rsp_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
